// File: rtl/rtc_bus_pkg.sv
// Shared types and bus-level constants for the RTC multiplexed-bus master.
package rtc_bus_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 9;
    localparam int DEF_PHASE_CYC = 4;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;
    localparam logic AD_ADDR = 1'b0;
    localparam logic AD_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP
    } bus_state_t;

    typedef struct packed {
        logic cs;
        logic rd;
        logic wr;
        logic ad;
        logic oe;
    } bus_ctl_t;

    // Strobe/enable levels for the state being entered; rd_ph selects a read data phase.
    function automatic bus_ctl_t bus_drive(input bus_state_t st, input logic rd_ph);
        bus_ctl_t c;
        c = '{cs: STB_OFF, rd: STB_OFF, wr: STB_OFF, ad: AD_DATA, oe: 1'b0};
        case (st)
            A_SET, A_HLD: begin
                c.cs = STB_ON;
                c.ad = AD_ADDR;
                c.oe = 1'b1;
            end
            A_STB: begin
                c.cs = STB_ON;
                c.ad = AD_ADDR;
                c.oe = 1'b1;
                c.wr = STB_ON;
            end
            D_SET, D_HLD: begin
                c.cs = STB_ON;
                c.oe = !rd_ph;
            end
            D_STB: begin
                c.cs = STB_ON;
                c.oe = !rd_ph;
                if (rd_ph) c.rd = STB_ON;
                else       c.wr = STB_ON;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Phase down-counter: reloads on load and flags the first and last cycle of a phase.
module rtc_bus_phase_timer #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_first,
    output logic phase_last
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] TOP = CNT_W'(PHASE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || load) cnt <= TOP;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign phase_first = (cnt == TOP);
    assign phase_last  = (cnt == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Burst master for the RTC multiplexed address/data bus.
// Define RTC_BUS_VERIFY_EN to read back and compare every written word.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int PHASE_CYC = DEF_PHASE_CYC,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WRITE,
    input  logic [DATA_W-1:0] START_ADDR,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [DATA_W-1:0] WDATA,
    output logic              WDATA_REQ,
    output logic [DATA_W-1:0] RDATA,
    output logic              RDATA_VALID,
    output logic [LEN_W-1:0]  WORD_IDX,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              CS,
    output logic              RD,
    output logic              WR,
    output logic              AD,
    output logic [DATA_W-1:0] BUS_O,
    output logic              BUS_OE,
    input  logic [DATA_W-1:0] BUS_I
);

`ifdef RTC_BUS_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    bus_state_t        state, nxt_state;
    logic              wr_mode, verify_ph, nxt_verify, nxt_rd, rd_ph;
    logic [DATA_W-1:0] addr;
    logic [LEN_W-1:0]  len_q, word_cnt;
    logic              accept, load, last_word, phase_first, phase_last;

    assign accept    = (state == IDLE) && REQ && (LEN != '0);
    assign load      = accept || (state != IDLE && phase_last);
    assign last_word = (word_cnt == len_q - 1'b1);
    assign rd_ph     = !wr_mode || verify_ph;

    rtc_bus_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk         (CLK),
        .rst_n       (RST),
        .load        (load),
        .phase_first (phase_first),
        .phase_last  (phase_last)
    );

    // A write word in verify builds is followed by a read of the same address.
    always_comb begin
        nxt_state  = state;
        nxt_verify = verify_ph;
        case (state)
            IDLE: if (accept) begin
                nxt_state  = A_SET;
                nxt_verify = 1'b0;
            end
            GAP: if (phase_last) begin
                if (VERIFY_EN && wr_mode && !verify_ph) begin
                    nxt_state  = A_SET;
                    nxt_verify = 1'b1;
                end else begin
                    nxt_verify = 1'b0;
                    nxt_state  = last_word ? IDLE : A_SET;
                end
            end
            default: if (phase_last) nxt_state = bus_state_t'(state + 3'd1);
        endcase
        nxt_rd = accept ? !WRITE : (!wr_mode || nxt_verify);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            verify_ph   <= 1'b0;
            wr_mode     <= 1'b0;
            addr        <= '0;
            len_q       <= '0;
            word_cnt    <= '0;
            {CS, RD, WR, AD, BUS_OE} <= {STB_OFF, STB_OFF, STB_OFF, AD_DATA, 1'b0};
            BUS_O       <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RDATA       <= '0;
            RDATA_VALID <= 1'b0;
            WDATA_REQ   <= 1'b0;
            WORD_IDX    <= '0;
        end else begin
            state     <= nxt_state;
            verify_ph <= nxt_verify;
            {CS, RD, WR, AD, BUS_OE} <= bus_drive(nxt_state, nxt_rd);
            DONE        <= 1'b0;
            RDATA_VALID <= 1'b0;
            WDATA_REQ   <= 1'b0;
            if (accept) begin
                wr_mode   <= WRITE;
                addr      <= START_ADDR;
                BUS_O     <= START_ADDR;
                len_q     <= (LEN > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : LEN;
                word_cnt  <= '0;
                WORD_IDX  <= '0;
                BUSY      <= 1'b1;
                WDATA_REQ <= WRITE;
            end
            // Write data goes on the bus one cycle into D_SET, giving WDATA 3 phases to settle.
            if (state == D_SET && phase_first && !rd_ph) BUS_O <= WDATA;
            if (state == D_STB && phase_last && rd_ph && !verify_ph) begin
                RDATA       <= BUS_I;
                RDATA_VALID <= 1'b1;
            end
            if (state == GAP && phase_last) begin
                if (nxt_verify) begin
                    BUS_O <= addr;
                end else if (last_word) begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end else begin
                    addr      <= addr + 1'b1;
                    BUS_O     <= addr + 1'b1;
                    word_cnt  <= word_cnt + 1'b1;
                    WDATA_REQ <= wr_mode;
                    if (!ERR) WORD_IDX <= word_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RTC_BUS_VERIFY_EN
    logic [DATA_W-1:0] wdata_q;

    // Sticky mismatch flag; WORD_IDX stops advancing once it is set.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ERR     <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (accept) ERR <= 1'b0;
            else if (state == D_STB && phase_last && verify_ph && BUS_I != wdata_q) ERR <= 1'b1;
            if (state == D_SET && phase_first && !rd_ph) wdata_q <= WDATA;
        end
    end
`else
    assign ERR = 1'b0;
`endif

endmodule
